ms_down_counter: RTL and testbench
==================================

// Module: ms_down_counter
// PURPOSE
//   Loadable multi-digit BCD down-counter for the minesweeper datapath: the game countdown
//   timer and the remaining-mines display. It counts from a loaded value down to zero on
//   qualified ticks and emits a one-cycle borrow/expire pulse at zero. It is the decrementing
//   counterpart of the generic wrap counter and feeds the 7-segment display driver.
// PARAMETERS
//   DIGITS      3        number of BCD digits; q width = 4*DIGITS
//   RESET_VAL   12'h999  BCD value loaded into q at reset (4*DIGITS bits)
// PORTS
//   clk        in   1          clock, all state on rising edge
//   rst        in   1          synchronous, active-high reset
//   load       in   1          load load_val into q, go to IDLE
//   load_val   in   4*DIGITS   BCD value to load; a digit > 9 is clamped to 9
//   start      in   1          IDLE/PAUSE -> RUN
//   stop       in   1          RUN -> PAUSE
//   tick       in   1          count enable (1-cycle strobe from prescaler)
//   q          out  4*DIGITS   current BCD count, registered
//   zero       out  1          q == 0, combinational from q
//   bo         out  1          registered borrow pulse, 1 cycle, when q reaches 0 in RUN
//   running    out  1          state == RUN
//   expired    out  1          state == EXPIRED
// BEHAVIOUR
//   - Reset: q=RESET_VAL, state=IDLE, bo=0; hence running=0, expired=0, zero=(RESET_VAL==0).
//   - States: IDLE, RUN, PAUSE, EXPIRED. Priority per cycle: rst > load > start/stop > tick.
//   - IDLE: start -> RUN. tick ignored.
//   - RUN: stop -> PAUSE (a tick in the same cycle is dropped). tick with q>1 -> q=q-1 (BCD).
//     tick with q==1 -> q=0, state=EXPIRED, bo=1 on the next cycle only.
//     q==0 on entering RUN (e.g. load 0 then start) -> EXPIRED one cycle later, bo pulsed once.
//   - PAUSE: start -> RUN. tick ignored. stop ignored.
//   - EXPIRED: q held at 0, tick/start/stop ignored; only load or rst leave this state.
//   - load in any state: q=clamp(load_val), state=IDLE, bo=0 next cycle; start/tick dropped.
//   - BCD decrement: a digit 0 with borrow-in becomes 9 and propagates borrow; q never wraps
//     below 0 (no ...999 underflow); all stored digits are always in 0..9.
//   - Latency: q updates the cycle after the tick edge; zero follows q combinationally.
//   - Simultaneous start+stop: in RUN stop wins; in IDLE/PAUSE start wins.
// CONFIGURATION
//   MS_DOWN_COUNTER_UP_EN defined: adds input `up` (1 bit) and output `co` (1 bit, registered
//     pulse). In RUN or PAUSE, tick&up -> q=q+1 (BCD), saturating at all-9s, with co=1 for one
//     cycle when all-9s is reached. This increment is used by the mine counter when a flag is
//     removed. up has priority over the down-count; up is ignored in IDLE/EXPIRED.
//   Not defined: no `up`/`co` ports, down-count only.
// STRUCTURE
//   ms_pkg: state enum (MS_DC_IDLE/RUN/PAUSE/EXPIRED, 2 bits), BCD_MAX=4'd9, clamp function.
//   Sub-module ms_bcd_digit: one 4-bit BCD digit with load, borrow-in/out (and carry-in/out
//   under MS_DOWN_COUNTER_UP_EN), instantiated DIGITS times in a generate chain; FSM and
//   pulse registers live in ms_down_counter.
// TESTING
//   1 rst, DIGITS=3 -> q=999, IDLE, bo=0; tick x5 in IDLE -> q stays 999.
//   2 load 100, start, tick x1 -> q=099; tick x98 -> q=001; tick -> q=000, expired=1,
//     bo high exactly 1 cycle; further ticks/start -> q=000.
//   3 load 3A5 (invalid digit) -> q=395; load 000 + start -> EXPIRED next cycle, single bo.
//   4 RUN q=050, stop+tick same cycle -> PAUSE, q=050; tick x3 -> 050; start, tick -> 049.
//   5 RUN, load 020 + tick same cycle -> q=020, IDLE; rst mid-RUN -> q=999, IDLE.
//   6 (UP_EN) q=998 PAUSE, tick&up -> 999, co 1 cycle; tick&up again -> 999, no co.

Source files
------------

// File: rtl/ms_pkg.sv
// Shared definitions for the minesweeper BCD down-counter.
//   ms_dc_state_e : counter control states (2-bit encoding)
//   BCD_MAX       : largest legal BCD digit
//   bcd_clamp()   : forces a digit above 9 down to 9
package ms_pkg;

   typedef enum logic [1:0] {
      MS_DC_IDLE    = 2'd0,
      MS_DC_RUN     = 2'd1,
      MS_DC_PAUSE   = 2'd2,
      MS_DC_EXPIRED = 2'd3
   } ms_dc_state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction

endpackage

// File: rtl/ms_down_counter_if.sv
// Control/status bundle of the BCD down-counter.
//   master : whoever drives load/start/stop/tick (and up) and watches the count
//   slave  : the counter itself
// Optional macro MS_DOWN_COUNTER_UP_EN adds the up request and co pulse.
interface ms_down_counter_if #(
   parameter int DIGITS = 3
);

   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  start;
   logic                  stop;
   logic                  tick;
   logic [4*DIGITS-1:0]   q;
   logic                  zero;
   logic                  bo;
   logic                  running;
   logic                  expired;
`ifdef MS_DOWN_COUNTER_UP_EN
   logic                  up;
   logic                  co;

   modport master (
      output load, load_val, start, stop, tick, up,
      input  q, zero, bo, running, expired, co
   );

   modport slave (
      input  load, load_val, start, stop, tick, up,
      output q, zero, bo, running, expired, co
   );
`else
   modport master (
      output load, load_val, start, stop, tick,
      input  q, zero, bo, running, expired
   );

   modport slave (
      input  load, load_val, start, stop, tick,
      output q, zero, bo, running, expired
   );
`endif

endinterface

// File: rtl/ms_bcd_digit.sv
// One BCD digit of the counter chain.
//   clk, rst    : clock, synchronous active-high reset (digit -> RESET_DIGIT)
//   load_en     : load load_digit (already clamped by the caller)
//   dec_en/bin  : decrement when both are high; bout = bin and digit is 0
//   inc_en/cin  : increment when both are high; cout = cin and digit is 9
//                 (only with MS_DOWN_COUNTER_UP_EN)
//   d           : stored digit, always within 0..9
module ms_bcd_digit
   import ms_pkg::*;
#(
   parameter logic [3:0] RESET_DIGIT = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_en,
   input  logic [3:0] load_digit,
   input  logic       dec_en,
   input  logic       bin,
`ifdef MS_DOWN_COUNTER_UP_EN
   input  logic       inc_en,
   input  logic       cin,
   output logic       cout,
`endif
   output logic       bout,
   output logic [3:0] d
);

   // Borrow/carry ripple is independent of the enables, so the top can use
   // the chain ends as zero / all-nines detectors.
   assign bout = bin && (d == 4'd0);
`ifdef MS_DOWN_COUNTER_UP_EN
   assign cout = cin && (d == BCD_MAX);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         d <= bcd_clamp(RESET_DIGIT);
      end else if (load_en) begin
         d <= load_digit;
      end else if (dec_en && bin) begin
         d <= (d == 4'd0) ? BCD_MAX : d - 4'd1;
`ifdef MS_DOWN_COUNTER_UP_EN
      end else if (inc_en && cin) begin
         d <= (d == BCD_MAX) ? 4'd0 : d + 4'd1;
`endif
      end
   end

endmodule

// File: rtl/ms_down_counter.sv
// Loadable multi-digit BCD down-counter (game timer / remaining-mines count).
// Counts down on tick while running, pulses bo for one cycle on reaching zero
// and then parks in EXPIRED until load or rst.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ms_down_counter_if.slave (load/load_val/start/stop/tick in,
//              q/zero/bo/running/expired out)
// Optional macro MS_DOWN_COUNTER_UP_EN: adds bus.up (saturating count-up on
// tick in RUN/PAUSE) and bus.co (one-cycle pulse when all-nines is reached).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | loaded/reset, waiting for start; ticks ignored
//   RUN     | counting down on tick; q==0 here expires next cycle
//   PAUSE   | count frozen (except up ticks); start resumes
//   EXPIRED | q held at 0; only load or rst leave
module ms_down_counter
   import ms_pkg::*;
#(
   parameter int                  DIGITS    = 3,
   parameter logic [4*DIGITS-1:0] RESET_VAL = {DIGITS{4'h9}}
) (
   input logic              clk,
   input logic              rst,
   ms_down_counter_if.slave bus
);

   localparam int              W        = 4 * DIGITS;
   localparam logic [W-1:0]    BCD_ONE  = {{(W-1){1'b0}}, 1'b1};

   ms_dc_state_e   state;
   logic [W-1:0]   q;
   logic [DIGITS:0] borrow;
   logic           q_zero;
   logic           dec_fire;
   logic           bo_r;

   // With borrow-in forced at the bottom, the borrow leaving the top digit
   // is exactly "every digit is zero".
   assign borrow[0] = 1'b1;
   assign q_zero    = borrow[DIGITS];

`ifdef MS_DOWN_COUNTER_UP_EN
   localparam logic [W-1:0] BCD_ALMOST = {{(DIGITS-1){BCD_MAX}}, 4'd8};

   logic [DIGITS:0] carry;
   logic            q_all9;
   logic            inc_fire;
   logic            co_r;

   assign carry[0] = 1'b1;
   assign q_all9   = carry[DIGITS];
`endif

   always_comb begin
      dec_fire = 1'b0;
`ifdef MS_DOWN_COUNTER_UP_EN
      inc_fire = 1'b0;
`endif
      if (!bus.load) begin
         case (state)
            MS_DC_RUN: begin
               if (!bus.stop && bus.tick && !q_zero) begin
`ifdef MS_DOWN_COUNTER_UP_EN
                  // up wins over the down-count; at all-nines the tick is consumed
                  if (bus.up) inc_fire = !q_all9;
                  else        dec_fire = 1'b1;
`else
                  dec_fire = 1'b1;
`endif
               end
            end
`ifdef MS_DOWN_COUNTER_UP_EN
            MS_DC_PAUSE: begin
               if (!bus.start && bus.tick && bus.up) inc_fire = !q_all9;
            end
`endif
            default: ;
         endcase
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      ms_bcd_digit #(
         .RESET_DIGIT (RESET_VAL[4*i +: 4])
      ) u_digit (
         .clk        (clk),
         .rst        (rst),
         .load_en    (bus.load),
         .load_digit (bcd_clamp(bus.load_val[4*i +: 4])),
         .dec_en     (dec_fire),
         .bin        (borrow[i]),
`ifdef MS_DOWN_COUNTER_UP_EN
         .inc_en     (inc_fire),
         .cin        (carry[i]),
         .cout       (carry[i+1]),
`endif
         .bout       (borrow[i+1]),
         .d          (q[4*i +: 4])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MS_DC_IDLE;
         bo_r  <= 1'b0;
`ifdef MS_DOWN_COUNTER_UP_EN
         co_r  <= 1'b0;
`endif
      end else begin
         bo_r <= 1'b0;
`ifdef MS_DOWN_COUNTER_UP_EN
         co_r <= inc_fire && (q == BCD_ALMOST);
`endif
         if (bus.load) begin
            state <= MS_DC_IDLE;
         end else begin
            case (state)
               MS_DC_IDLE: begin
                  if (bus.start) state <= MS_DC_RUN;
               end
               MS_DC_RUN: begin
                  if (bus.stop) begin
                     state <= MS_DC_PAUSE;
                  end else if (q_zero) begin
                     // entered RUN already at zero
                     state <= MS_DC_EXPIRED;
                     bo_r  <= 1'b1;
                  end else if (dec_fire && (q == BCD_ONE)) begin
                     state <= MS_DC_EXPIRED;
                     bo_r  <= 1'b1;
                  end
               end
               MS_DC_PAUSE: begin
                  if (bus.start) state <= MS_DC_RUN;
               end
               MS_DC_EXPIRED: ;
               default: state <= MS_DC_IDLE;
            endcase
         end
      end
   end

   assign bus.q       = q;
   assign bus.zero    = q_zero;
   assign bus.bo      = bo_r;
   assign bus.running = (state == MS_DC_RUN);
   assign bus.expired = (state == MS_DC_EXPIRED);
`ifdef MS_DOWN_COUNTER_UP_EN
   assign bus.co      = co_r;
`endif

endmodule

// File: tb/tb_ms_down_counter.sv
// Self-checking bench for ms_down_counter (DIGITS=3, RESET_VAL=999).
// Reference model keeps the count as a plain decimal integer.
module tb_ms_down_counter;

   localparam int MAXV = 999;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
`ifdef MS_DOWN_COUNTER_UP_EN
   localparam bit UP = 1'b1;
`else
   localparam bit UP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   ms_down_counter_if #(.DIGITS(3)) bus ();

   ms_down_counter #(.DIGITS(3), .RESET_VAL(12'h999)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   int m_q  = MAXV;
   int m_st = S_IDLE;
   bit m_bo = 1'b0;
   bit m_co = 1'b0;

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int from_bcd_clamped(input logic [11:0] x);
      int s, p, dg;
      s = 0;
      p = 1;
      for (int i = 0; i < 3; i++) begin
         dg = int'(x[4*i +: 4]);
         if (dg > 9) dg = 9;
         s = s + dg * p;
         p = p * 10;
      end
      return s;
   endfunction

   // Reference behaviour for one clock edge, from the pre-edge model state.
   task automatic model_edge(input bit r, input bit ld, input logic [11:0] lv,
                             input bit st, input bit sp, input bit tk, input bit u);
      bit up_eff;
      up_eff = UP && u;
      m_bo = 1'b0;
      m_co = 1'b0;
      if (r) begin
         m_q  = MAXV;
         m_st = S_IDLE;
      end else if (ld) begin
         m_q  = from_bcd_clamped(lv);
         m_st = S_IDLE;
      end else if (m_st == S_IDLE) begin
         if (st) m_st = S_RUN;
      end else if (m_st == S_RUN) begin
         if (sp) m_st = S_PAUSE;
         else if (m_q == 0) begin
            m_st = S_EXP;
            m_bo = 1'b1;
         end else if (tk && up_eff) begin
            if (m_q < MAXV) begin
               m_q  = m_q + 1;
               m_co = (m_q == MAXV);
            end
         end else if (tk) begin
            m_q = m_q - 1;
            if (m_q == 0) begin
               m_st = S_EXP;
               m_bo = 1'b1;
            end
         end
      end else if (m_st == S_PAUSE) begin
         if (st) m_st = S_RUN;
         else if (tk && up_eff && m_q < MAXV) begin
            m_q  = m_q + 1;
            m_co = (m_q == MAXV);
         end
      end
   endtask

   task automatic step(input bit r, input bit ld, input logic [11:0] lv,
                       input bit st, input bit sp, input bit tk, input bit u);
      rst          = r;
      bus.load     = ld;
      bus.load_val = lv;
      bus.start    = st;
      bus.stop     = sp;
      bus.tick     = tk;
`ifdef MS_DOWN_COUNTER_UP_EN
      bus.up       = u;
`endif
      @(posedge clk);
      model_edge(r, ld, lv, st, sp, tk, u);
      #1;
      rst       = 1'b0;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.tick  = 1'b0;
`ifdef MS_DOWN_COUNTER_UP_EN
      bus.up    = 1'b0;
`endif
   endtask

   task automatic test_reset();
      step(1, 0, 12'h000, 0, 0, 0, 0);
      total++; if (bus.q !== 12'h999) $display("FAIL reset_q got=%h want=%h", bus.q, 12'h999); else passed++;
      total++; if (bus.running !== 1'b0) $display("FAIL reset_running got=%b want=0", bus.running); else passed++;
      total++; if (bus.expired !== 1'b0) $display("FAIL reset_expired got=%b want=0", bus.expired); else passed++;
      total++; if (bus.bo !== 1'b0) $display("FAIL reset_bo got=%b want=0", bus.bo); else passed++;
      total++; if (bus.zero !== 1'b0) $display("FAIL reset_zero got=%b want=0", bus.zero); else passed++;
      for (int i = 0; i < 5; i++) step(0, 0, 12'h000, 0, 0, 1, 0);
      total++; if (bus.q !== 12'h999) $display("FAIL idle_tick_q got=%h want=%h", bus.q, 12'h999); else passed++;
   endtask

   task automatic test_countdown();
      step(0, 1, 12'h100, 0, 0, 0, 0);
      step(0, 0, 12'h000, 1, 0, 0, 0);
      total++; if (bus.running !== 1'b1) $display("FAIL cd_running got=%b want=1", bus.running); else passed++;
      step(0, 0, 12'h000, 0, 0, 1, 0);
      total++; if (bus.q !== 12'h099) $display("FAIL cd_q099 got=%h want=%h", bus.q, 12'h099); else passed++;
      for (int i = 0; i < 98; i++) step(0, 0, 12'h000, 0, 0, 1, 0);
      total++; if (bus.q !== 12'h001) $display("FAIL cd_q001 got=%h want=%h", bus.q, 12'h001); else passed++;
      total++; if (bus.bo !== 1'b0) $display("FAIL cd_bo_early got=%b want=0", bus.bo); else passed++;
      step(0, 0, 12'h000, 0, 0, 1, 0);
      total++; if (bus.q !== 12'h000) $display("FAIL cd_q000 got=%h want=%h", bus.q, 12'h000); else passed++;
      total++; if (bus.expired !== 1'b1) $display("FAIL cd_expired got=%b want=1", bus.expired); else passed++;
      total++; if (bus.bo !== 1'b1) $display("FAIL cd_bo_pulse got=%b want=1", bus.bo); else passed++;
      total++; if (bus.zero !== 1'b1) $display("FAIL cd_zero got=%b want=1", bus.zero); else passed++;
      step(0, 0, 12'h000, 0, 0, 1, 0);
      total++; if (bus.bo !== 1'b0) $display("FAIL cd_bo_one_cycle got=%b want=0", bus.bo); else passed++;
      step(0, 0, 12'h000, 1, 0, 1, 0);
      step(0, 0, 12'h000, 0, 1, 1, 0);
      total++; if (bus.q !== 12'h000) $display("FAIL cd_hold_q got=%h want=%h", bus.q, 12'h000); else passed++;
      total++; if (bus.expired !== 1'b1) $display("FAIL cd_hold_expired got=%b want=1", bus.expired); else passed++;
   endtask

   task automatic test_clamp_and_zero_load();
      step(0, 1, 12'h3A5, 0, 0, 0, 0);
      total++; if (bus.q !== 12'h395) $display("FAIL clamp_q got=%h want=%h", bus.q, 12'h395); else passed++;
      total++; if (bus.expired !== 1'b0) $display("FAIL clamp_expired got=%b want=0", bus.expired); else passed++;
      step(0, 1, 12'h000, 0, 0, 0, 0);
      step(0, 0, 12'h000, 1, 0, 0, 0);
      total++; if (bus.running !== 1'b1) $display("FAIL zl_running got=%b want=1", bus.running); else passed++;
      total++; if (bus.bo !== 1'b0) $display("FAIL zl_bo_early got=%b want=0", bus.bo); else passed++;
      step(0, 0, 12'h000, 0, 0, 0, 0);
      total++; if (bus.expired !== 1'b1) $display("FAIL zl_expired got=%b want=1", bus.expired); else passed++;
      total++; if (bus.bo !== 1'b1) $display("FAIL zl_bo got=%b want=1", bus.bo); else passed++;
      step(0, 0, 12'h000, 0, 0, 0, 0);
      total++; if (bus.bo !== 1'b0) $display("FAIL zl_bo_single got=%b want=0", bus.bo); else passed++;
   endtask

   task automatic test_pause();
      step(0, 1, 12'h050, 0, 0, 0, 0);
      step(0, 0, 12'h000, 1, 0, 0, 0);
      step(0, 0, 12'h000, 0, 1, 1, 0);
      total++; if (bus.q !== 12'h050) $display("FAIL pause_q got=%h want=%h", bus.q, 12'h050); else passed++;
      total++; if (bus.running !== 1'b0) $display("FAIL pause_running got=%b want=0", bus.running); else passed++;
      for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0, 0, 1, 0);
      total++; if (bus.q !== 12'h050) $display("FAIL pause_tick_q got=%h want=%h", bus.q, 12'h050); else passed++;
      step(0, 0, 12'h000, 1, 1, 0, 0);
      total++; if (bus.running !== 1'b1) $display("FAIL pause_startwins got=%b want=1", bus.running); else passed++;
      step(0, 0, 12'h000, 0, 0, 1, 0);
      total++; if (bus.q !== 12'h049) $display("FAIL resume_q got=%h want=%h", bus.q, 12'h049); else passed++;
   endtask

   task automatic test_load_priority_and_rst();
      step(0, 1, 12'h020, 1, 0, 1, 0);
      total++; if (bus.q !== 12'h020) $display("FAIL ldpri_q got=%h want=%h", bus.q, 12'h020); else passed++;
      total++; if (bus.running !== 1'b0) $display("FAIL ldpri_running got=%b want=0", bus.running); else passed++;
      step(0, 0, 12'h000, 1, 0, 0, 0);
      step(0, 0, 12'h000, 0, 0, 1, 0);
      total++; if (bus.q !== 12'h019) $display("FAIL ld_borrow_q got=%h want=%h", bus.q, 12'h019); else passed++;
      step(1, 0, 12'h000, 0, 0, 1, 0);
      total++; if (bus.q !== 12'h999) $display("FAIL rst_run_q got=%h want=%h", bus.q, 12'h999); else passed++;
      total++; if (bus.running !== 1'b0) $display("FAIL rst_run_running got=%b want=0", bus.running); else passed++;
   endtask

`ifdef MS_DOWN_COUNTER_UP_EN
   task automatic test_up();
      step(0, 1, 12'h998, 0, 0, 0, 0);
      step(0, 0, 12'h000, 1, 0, 0, 0);
      step(0, 0, 12'h000, 0, 1, 0, 0);
      step(0, 0, 12'h000, 0, 0, 1, 1);
      total++; if (bus.q !== 12'h999) $display("FAIL up_q got=%h want=%h", bus.q, 12'h999); else passed++;
      total++; if (bus.co !== 1'b1) $display("FAIL up_co got=%b want=1", bus.co); else passed++;
      step(0, 0, 12'h000, 0, 0, 1, 1);
      total++; if (bus.q !== 12'h999) $display("FAIL up_sat_q got=%h want=%h", bus.q, 12'h999); else passed++;
      total++; if (bus.co !== 1'b0) $display("FAIL up_sat_co got=%b want=0", bus.co); else passed++;
   endtask
`endif

   task automatic test_random();
      logic [11:0] lv;
      bit r, ld, st, sp, tk, u;
      step(1, 0, 12'h000, 0, 0, 0, 0);
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 199) == 0);
         ld = ($urandom_range(0, 24) == 0);
         st = ($urandom_range(0, 6) == 0);
         sp = ($urandom_range(0, 11) == 0);
         tk = ($urandom_range(0, 1) == 1);
         u  = ($urandom_range(0, 3) == 0);
         lv = 12'($urandom);
         if ($urandom_range(0, 1) == 1) lv[11:4] = 8'($urandom_range(0, 1));
         step(r, ld, lv, st, sp, tk, u);
         total++; if (bus.q !== to_bcd(m_q)) $display("FAIL rnd_q n=%0d got=%h want=%h", n, bus.q, to_bcd(m_q)); else passed++;
         total++; if (bus.bo !== m_bo) $display("FAIL rnd_bo n=%0d got=%b want=%b", n, bus.bo, m_bo); else passed++;
         total++; if (bus.running !== (m_st == S_RUN)) $display("FAIL rnd_running n=%0d got=%b want=%b", n, bus.running, (m_st == S_RUN)); else passed++;
         total++; if (bus.expired !== (m_st == S_EXP)) $display("FAIL rnd_expired n=%0d got=%b want=%b", n, bus.expired, (m_st == S_EXP)); else passed++;
         total++; if (bus.zero !== (m_q == 0)) $display("FAIL rnd_zero n=%0d got=%b want=%b", n, bus.zero, (m_q == 0)); else passed++;
`ifdef MS_DOWN_COUNTER_UP_EN
         total++; if (bus.co !== m_co) $display("FAIL rnd_co n=%0d got=%b want=%b", n, bus.co, m_co); else passed++;
`endif
      end
   endtask

   initial begin
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.tick     = 1'b0;
`ifdef MS_DOWN_COUNTER_UP_EN
      bus.up       = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_countdown();
      test_clamp_and_zero_load();
      test_pause();
      test_load_priority_and_rst();
`ifdef MS_DOWN_COUNTER_UP_EN
      test_up();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
